// File: rtl/conv2d_compute_stream.sv
// conv2d_compute_stream: single-MAC conv2D engine; loads a kernel, then sweeps the whole OFM with zero-padded halo.
// Optional macro RELU_EN clamps negative results to zero on wdata.
module conv2d_compute_stream #(
  parameter int DWIDTH     = 32,
  parameter int WT_DIM_MAX = 5,
  parameter int CWIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(WT_DIM_MAX+1)-1:0] wt_dim,
  input  logic [CWIDTH-1:0]               fm_dim,
  output logic                            idle,
  output logic                            done,
  output logic [CWIDTH-1:0]               cur_x,
  output logic [CWIDTH-1:0]               cur_y,
  output logic [$clog2(WT_DIM_MAX)-1:0]   cur_m,
  output logic [$clog2(WT_DIM_MAX)-1:0]   cur_n,
  input  logic [DWIDTH-1:0]               rdata,
  input  logic                            rdata_valid,
  output logic                            rdata_ready,
  output logic [DWIDTH-1:0]               wdata,
  output logic                            wdata_valid,
  input  logic                            wdata_ready
);
  localparam int WW = $clog2(WT_DIM_MAX + 1);
  localparam int MW = $clog2(WT_DIM_MAX);
  localparam int KW = $clog2(WT_DIM_MAX * WT_DIM_MAX);
  localparam int IW = CWIDTH + 2;

  typedef enum logic [2:0] {IDLE, READ_WT, COMPUTE, DRAIN, OUT} state_t;
  state_t state, state_nx;

  logic [WW-1:0] wd;
  logic [CWIDTH-1:0] fd, x, y;
  logic [MW-1:0] m, n;
  logic drain_cnt;
  logic signed [DWIDTH-1:0] wt [WT_DIM_MAX*WT_DIM_MAX];
  logic signed [DWIDTH-1:0] s1_d, s1_w, acc;
  logic s1_v;

  logic start_ok, rd_fire, wr_fire, n_last, m_last, x_last, pix_last, halo, adv, step;
  logic signed [IW-1:0] half, idx, idy, fds;
  logic [KW-1:0] widx;

  assign start_ok    = start && wt_dim[0] && wt_dim <= WW'(WT_DIM_MAX) && fm_dim != '0;
  assign half        = $signed(IW'(wd >> 1));
  assign idx         = $signed(IW'(x)) - half + $signed(IW'(n));
  assign idy         = $signed(IW'(y)) - half + $signed(IW'(m));
  assign fds         = $signed(IW'(fd));
  assign halo        = idx[IW-1] || idy[IW-1] || idx >= fds || idy >= fds;
  assign widx        = KW'(m) * KW'(wd) + KW'(n);
  assign n_last      = WW'(n) == wd - WW'(1);
  assign m_last      = WW'(m) == wd - WW'(1);
  assign x_last      = x == fd - CWIDTH'(1);
  assign pix_last    = x_last && y == fd - CWIDTH'(1);
  assign idle        = state == IDLE;
  assign rdata_ready = state == READ_WT || (state == COMPUTE && !halo);
  assign wdata_valid = state == OUT;
  assign rd_fire     = rdata_valid && rdata_ready;
  assign wr_fire     = wdata_valid && wdata_ready;
  assign adv         = state == COMPUTE && (halo || rdata_valid);
  assign step        = (state == READ_WT && rd_fire) || adv;
  assign cur_x       = x;
  assign cur_y       = y;
  assign cur_m       = m;
  assign cur_n       = n;
`ifdef RELU_EN
  assign wdata       = acc[DWIDTH-1] ? '0 : acc;
`else
  assign wdata       = acc;
`endif

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;

  // next-state: weight load, window sweep, pipeline drain, output handshake
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_ok ? READ_WT : IDLE;
      READ_WT: state_nx = rd_fire && n_last && m_last ? COMPUTE : READ_WT;
      COMPUTE: state_nx = adv && n_last && m_last ? DRAIN : COMPUTE;
      DRAIN:   state_nx = drain_cnt ? OUT : DRAIN;
      OUT:     state_nx = wr_fire ? (pix_last ? IDLE : COMPUTE) : OUT;
      default: state_nx = IDLE;
    endcase
  end

  // kernel (m,n) and pixel (x,y) counters, run configuration, done pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {x, y, m, n, wd, fd, drain_cnt, done} <= '0;
    end else begin
      done      <= wr_fire && pix_last;
      drain_cnt <= state == DRAIN ? !drain_cnt : 1'b0;
      if (state == IDLE && start_ok) begin
        wd <= wt_dim;
        fd <= fm_dim;
        {x, y, m, n} <= '0;
      end else if (step) begin
        n <= n_last ? '0 : n + MW'(1);
        m <= n_last ? (m_last ? '0 : m + MW'(1)) : m;
      end else if (wr_fire && !pix_last) begin
        {m, n} <= '0;
        x <= x_last ? '0 : x + CWIDTH'(1);
        y <= x_last ? y + CWIDTH'(1) : y;
      end
    end

  // weight register file, written row-major during the load phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < WT_DIM_MAX * WT_DIM_MAX; i++) wt[i] <= '0;
    end else if (state == READ_WT && rd_fire) begin
      wt[widx] <= $signed(rdata);
    end

  // two-stage MAC: register operands, then accumulate; cleared when the result is taken
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {s1_d, s1_w, acc, s1_v} <= '0;
    end else begin
      s1_v <= adv;
      s1_d <= halo ? '0 : $signed(rdata);
      s1_w <= wt[widx];
      acc  <= wr_fire ? '0 : (s1_v ? acc + s1_w * s1_d : acc);
    end
endmodule

// File: tb/tb_conv2d_compute_stream.sv
// tb_conv2d_compute_stream: randomized self-checking bench with a window-sum reference model.
module tb_conv2d_compute_stream;
  logic clk = 0, rst, start;
  logic [2:0] wt_dim;
  logic [15:0] fm_dim, cur_x, cur_y;
  logic idle, done, rdata_valid, rdata_ready, wdata_valid, wdata_ready;
  logic [2:0] cur_m, cur_n;
  logic [31:0] rdata, wdata;

  conv2d_compute_stream dut (
    .clk(clk), .rst(rst), .start(start), .wt_dim(wt_dim), .fm_dim(fm_dim),
    .idle(idle), .done(done), .cur_x(cur_x), .cur_y(cur_y), .cur_m(cur_m), .cur_n(cur_n),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int w_arr[25];
  int ifm[256];
  int exp_q[$];
  int rd_q[$];

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // expected outputs and the exact read stream a correct unit consumes
  task automatic build(input int wd, input int fd);
    int h, s, iy, ix;
    h = wd / 2;
    exp_q.delete();
    rd_q.delete();
    for (int i = 0; i < wd * wd; i++) rd_q.push_back(w_arr[i]);
    for (int y = 0; y < fd; y++)
      for (int x = 0; x < fd; x++) begin
        s = 0;
        for (int m = 0; m < wd; m++)
          for (int n = 0; n < wd; n++) begin
            iy = y - h + m;
            ix = x - h + n;
            if (iy >= 0 && iy < fd && ix >= 0 && ix < fd) begin
              s += w_arr[m * wd + n] * ifm[iy * fd + ix];
              rd_q.push_back(ifm[iy * fd + ix]);
            end
          end
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        exp_q.push_back(s);
      end
  endtask

  task automatic run_map(input int wd, input int fd, input int vpct, input bit stall, input int abort_cyc);
    int outs = 0, dones = 0, extra = 0, viol = 0, wait_cnt = 0, nrd = 0, h, ix, iy;
    bit fin = 0, prev_stall = 0, aborted = 0;
    logic [31:0] prev_w = '0;
    h = wd / 2;
    start = 1;
    wt_dim = 3'(wd);
    fm_dim = 16'(fd);
    rdata = rd_q.size() > 0 ? rd_q[0] : 0;
    rdata_valid = $urandom_range(99) < vpct;
    wdata_ready = 1;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(negedge clk);
      if (nrd >= wd * wd && rdata_ready) begin
        ix = int'(cur_x) - h + int'(cur_n);
        iy = int'(cur_y) - h + int'(cur_m);
        if (ix < 0 || iy < 0 || ix >= fd || iy >= fd) viol++;
      end
      if (wdata_valid && rdata_ready) viol++;
      if (prev_stall && (!wdata_valid || wdata !== prev_w)) viol++;
      if (rdata_valid && rdata_ready) begin
        nrd++;
        if (rd_q.size() == 0) extra++;
        else void'(rd_q.pop_front());
      end
      if (wdata_valid && wdata_ready) begin
        outs++;
        wait_cnt = 0;
        if (exp_q.size() == 0) extra++;
        else check("ofm", wdata, exp_q.pop_front());
      end
      prev_stall = wdata_valid && !wdata_ready;
      prev_w = wdata;
      if (done) begin
        dones++;
        fin = 1;
      end
      if (cyc == abort_cyc) begin
        #2 rst = 0;
        #1;
        check("rst_idle", idle, 1);
        check("rst_done", done, 0);
        check("rst_rrdy", rdata_ready, 0);
        check("rst_wval", wdata_valid, 0);
        check("rst_wdata", wdata, 0);
        check("rst_cur", {cur_x, cur_y[9:0], cur_m, cur_n}, 0);
        aborted = 1;
        break;
      end
      @(posedge clk);
      #1;
      start = 0;
      rdata_valid = $urandom_range(99) < vpct;
      rdata = rd_q.size() > 0 ? rd_q[0] : $urandom;
      wdata_ready = !(stall && wdata_valid && wait_cnt < 5);
      if (!wdata_ready) wait_cnt++;
    end
    start = 0;
    rdata_valid = 0;
    wdata_ready = 1;
    if (!aborted) begin
      check("finished", fin, 1);
      repeat (3) begin
        @(negedge clk);
        if (done) dones++;
      end
      check("done_cnt", dones, 1);
      check("idle_end", idle, 1);
      check("n_out", outs, fd * fd);
      check("reads_left", rd_q.size(), 0);
      check("extra", extra, 0);
      check("protocol", viol, 0);
    end
  endtask

  task automatic bad_start(input int wd, input int fd);
    start = 1;
    wt_dim = 3'(wd);
    fm_dim = 16'(fd);
    repeat (4) begin
      @(negedge clk);
      check("bad_idle", idle, 1);
      check("bad_rrdy", rdata_ready, 0);
      @(posedge clk);
      #1;
    end
    start = 0;
  endtask

  task automatic setup_s1();
    for (int i = 0; i < 9; i++) w_arr[i] = 1;
    for (int i = 0; i < 9; i++) ifm[i] = i + 1;
    build(3, 3);
    exp_q = '{12, 21, 16, 27, 45, 33, 24, 39, 28};
  endtask

  initial begin
    rst = 0;
    start = 0;
    wt_dim = 0;
    fm_dim = 0;
    rdata = 0;
    rdata_valid = 0;
    wdata_ready = 1;
    #1;
    check("init_idle", idle, 1);
    check("init_done", done, 0);
    check("init_rrdy", rdata_ready, 0);
    check("init_wval", wdata_valid, 0);
    check("init_wdata", wdata, 0);
    check("init_cur", {cur_x, cur_y[9:0], cur_m, cur_n}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    setup_s1();
    run_map(3, 3, 100, 0, -1);
    setup_s1();
    run_map(3, 3, 100, 1, -1);
    bad_start(4, 3);
    bad_start(7, 3);
    bad_start(3, 0);
    bad_start(0, 3);
    for (int i = 0; i < 25; i++) w_arr[i] = 0;
    w_arr[12] = 1;
    for (int i = 0; i < 16; i++) ifm[i] = int'($urandom_range(200)) - 100;
    build(5, 4);
    run_map(5, 4, 50, 0, -1);
    for (int i = 0; i < 9; i++) w_arr[i] = int'($urandom_range(20)) - 10;
    for (int i = 0; i < 25; i++) ifm[i] = int'($urandom_range(200)) - 100;
    build(3, 5);
    run_map(3, 5, 70, 1, -1);
    w_arr[0] = int'($urandom_range(20)) - 10;
    build(1, 4);
    run_map(1, 4, 60, 0, -1);
    build(3, 1);
    run_map(3, 1, 60, 0, -1);
    for (int i = 0; i < 25; i++) w_arr[i] = 0;
    w_arr[12] = 1;
    for (int i = 0; i < 16; i++) ifm[i] = int'($urandom_range(200)) - 100;
    build(5, 4);
    run_map(5, 4, 50, 0, 150);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    setup_s1();
    run_map(3, 3, 100, 0, -1);
    for (int i = 0; i < 9; i++) w_arr[i] = -1;
    for (int i = 0; i < 4; i++) ifm[i] = 5;
    build(3, 2);
    run_map(3, 2, 100, 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv2d_compute_stream.md
Name: conv2d_compute_stream

Overview:
- Next-generation conv2D compute unit with a single MAC.
- Loads a runtime-sized square weight kernel once, then sweeps the whole output feature map internally: OFM(0,0) to OFM(fm_dim-1, fm_dim-1), row-major.
- For every output pixel it streams the IFM window from DMem, with zero-padding of halo cells, and emits one result on a backpressured write channel to mem_if.
- It exports the current (y, x, m, n) indices so mem_if can generate read addresses.

Parameters:
DWIDTH, 32, data/weight/accumulator width (signed two's complement)
WT_DIM_MAX, 5, largest supported kernel dimension (odd); sizes the weight register file (WT_DIM_MAX*WT_DIM_MAX entries)
CWIDTH, 16, width of fm_dim and of the x/y index outputs

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = reset)
start  in  1  begin a full-map run; sampled only in IDLE
wt_dim  in  $clog2(WT_DIM_MAX+1)  kernel dimension; latched at accepted start
fm_dim  in  CWIDTH  IFM/OFM dimension; latched at accepted start
idle  out  1  high in IDLE
done  out  1  one-cycle pulse when the last OFM pixel's write handshake completes
cur_x  out  CWIDTH  current OFM column
cur_y  out  CWIDTH  current OFM row
cur_m  out  $clog2(WT_DIM_MAX)  current kernel row
cur_n  out  $clog2(WT_DIM_MAX)  current kernel column
rdata  in  DWIDTH  weight or IFM data from DMem
rdata_valid  in  1  rdata valid
rdata_ready  out  1  unit accepts rdata this cycle
wdata  out  DWIDTH  OFM result
wdata_valid  out  1  wdata valid
wdata_ready  in  1  mem_if accepts wdata

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, weights and accumulator cleared. Outputs: idle=1, done=0, rdata_ready=0, wdata_valid=0, wdata=0, cur_*=0.
- Start acceptance: start in IDLE is accepted only if wt_dim is odd, 1 <= wt_dim <= WT_DIM_MAX, and fm_dim != 0. Otherwise it is ignored and idle stays 1. start outside IDLE is ignored.
- Handshakes: rdata fire = rdata_valid & rdata_ready. wdata fire = wdata_valid & wdata_ready.
- States:
  - IDLE: accepted start -> READ_WT.
  - READ_WT:
    - rdata_ready=1. Each fire writes weight[m*wt_dim+n].
    - n advances 0..wt_dim-1; m advances when n wraps.
    - Fire at (m,n) = (wt_dim-1, wt_dim-1) -> COMPUTE with m=n=0, x=y=0.
  - COMPUTE:
    - Per cycle, idx = x - wt_dim/2 + n and idy = y - wt_dim/2 + m, both signed.
    - Halo if idx<0, idx>=fm_dim, idy<0 or idy>=fm_dim.
    - Halo cell: rdata_ready=0; the cell advances unconditionally with operand 0.
    - Non-halo cell: rdata_ready=1; the cell advances only on fire.
    - The last cell advancing -> DRAIN.
  - DRAIN: two cycles for the MAC pipeline, then -> OUT.
  - OUT:
    - wdata_valid=1; wdata is held stable until fire.
    - On fire: the accumulator clears.
    - If x=fm_dim-1 and y=fm_dim-1: -> IDLE and done pulses.
    - Else: x increments (on wrap, x=0 and y increments); m=n=0; -> COMPUTE.
- MAC pipeline:
  - Stage 1 registers the operand (rdata, or 0 for halo), weight[m*wt_dim+n], and an advance flag.
  - Stage 2: acc <= acc + w*d when the flag is set.
  - Signed multiply; product and sum truncated to DWIDTH (wrap, no saturation).
  - Accumulator latency from the last operand = 2 cycles, covered by DRAIN.
- Weights persist across pixels of one run. They are cleared only by reset, and are overwritten by the next run's READ_WT.
- wt_dim=1: no halo cells; each pixel takes 1 read.
- fm_dim=1: a single pixel; all cells except the centre are halo.
- cur_* reflect the registered counters every cycle, including while stalled.

Optional Feature:
RELU_EN
- Defined: wdata = acc if acc is non-negative (MSB=0), else 0. This is combinational on the held accumulator; timing is unchanged.
- Undefined: wdata = raw accumulator value.

Test Plan:
1. fm_dim=3, wt_dim=3, all weights 1, IFM 1..9 row-major, valid always high, ready always high -> 9 outputs: 12,21,16,27,45,33,24,39,28; done pulses once; idle returns to 1.
2. Same run as scenario 1 with wdata_ready held 0 for 5 cycles at each output -> wdata/wdata_valid stable while stalled; identical result sequence; no extra rdata consumed while in OUT.
3. fm_dim=4, wt_dim=5, identity kernel (centre weight 1, others 0), random IFM, rdata_valid toggled randomly -> OFM equals IFM. Reads per pixel equal the non-halo cell count (9 at corners); rdata_ready=0 on every halo cycle.
4. start with wt_dim=4, then start with wt_dim=7 (WT_DIM_MAX=5), then start with fm_dim=0 -> all ignored; idle stays 1; rdata_ready stays 0.
5. Assert rst=0 mid-COMPUTE of scenario 3 -> all outputs return to reset values asynchronously; a new start after release reproduces scenario 1's results exactly.
6. Weights all -1, IFM all 5, fm_dim=2, wt_dim=3 -> each output is -20; with RELU_EN defined every output is 0.
